dpi_stream_feeder: RTL and testbench

DPI_STREAM_FEEDER -- requirements
Module: dpi_stream_feeder

---
 rtl/dpi_feeder_pkg.sv | 17 +
 rtl/dpi_flow_table.sv | 62 ++++++
 rtl/dpi_stream_feeder.sv | 168 ++++++++++++++++
 tb/tb_dpi_stream_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_feeder_pkg.sv
// rtl/dpi_feeder_pkg.sv - shared FSM state encoding and stream table sizing for the DPI stream feeder
package dpi_feeder_pkg;

   localparam int STREAM_W    = 6;
   localparam int NUM_STREAMS = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_LOAD   = 3'd2,
      ST_GAP    = 3'd3,
      ST_STREAM = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_EOP    = 3'd6
   } feeder_state_t;

endpackage

// File: rtl/dpi_flow_table.sv
// rtl/dpi_flow_table.sv - 64-entry flow key table with parallel match and round-robin allocation
module dpi_flow_table
   import dpi_feeder_pkg::*;
#(
   parameter int KEY_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                lookup_en,
   input  logic [KEY_W-1:0]    key,
   output logic [STREAM_W-1:0] res_id,
   output logic                res_new
);

   logic [KEY_W-1:0]       keys_q [NUM_STREAMS];
   logic [KEY_W-1:0]       keys_d [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] valid_q, valid_d;
   logic [STREAM_W-1:0]    alloc_ptr_q, alloc_ptr_d;
   logic                   hit;
   logic [STREAM_W-1:0]    hit_idx;
   logic                   alloc;

   // Keys are unique in the table, so at most one entry can match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (valid_q[i] && (keys_q[i] == key)) begin
            hit     = 1'b1;
            hit_idx = STREAM_W'(i);
         end
      end
   end

   assign alloc   = lookup_en && !hit;
   assign res_id  = hit ? hit_idx : alloc_ptr_q;
   assign res_new = !hit;

   // Allocation simply overwrites at the pointer, which evicts the oldest entry once full.
   always_comb begin
      keys_d      = keys_q;
      valid_d     = valid_q;
      alloc_ptr_d = alloc_ptr_q;
      if (alloc) begin
         keys_d[alloc_ptr_q]  = key;
         valid_d[alloc_ptr_q] = 1'b1;
         alloc_ptr_d          = alloc_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      keys_q <= keys_d;
      if (!rst_n) begin
         valid_q     <= '0;
         alloc_ptr_q <= '0;
      end else begin
         valid_q     <= valid_d;
         alloc_ptr_q <= alloc_ptr_d;
      end
   end

endmodule

// File: rtl/dpi_stream_feeder.sv
// rtl/dpi_stream_feeder.sv - packet-to-matcher feeder FSM; DPI_FEEDER_STATS_EN adds pkt_cnt/new_cnt
module dpi_stream_feeder
   import dpi_feeder_pkg::*;
#(
   parameter int KEY_W   = 16,
   parameter int EOP_GAP = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          pkt_data,
   input  logic                pkt_vld,
   input  logic                pkt_sop,
   input  logic                pkt_eop,
   input  logic [KEY_W-1:0]    pkt_key,
   output logic                pkt_rdy,
   output logic [7:0]          char_in,
   output logic                char_in_vld,
   output logic                load_state,
   output logic [STREAM_W-1:0] stream_id,
   output logic                new_stream_id,
   output logic                eop,
   output logic                drop_err
`ifdef DPI_FEEDER_STATS_EN
   ,
   output logic [15:0]         pkt_cnt,
   output logic [15:0]         new_cnt
`endif
);

   localparam int CNT_W = (EOP_GAP < 2) ? 1 : $clog2(EOP_GAP + 1);

   feeder_state_t       state_q, state_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [STREAM_W-1:0] sid_q, sid_d;
   logic                new_q, new_d;
   logic [7:0]          char_q, char_d;
   logic                char_vld_q, char_vld_d;
   logic                drop_q, drop_d;
   logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic                rdy_c;
   logic [STREAM_W-1:0] tbl_id;
   logic                tbl_new;
   logic                lookup_en;

   assign lookup_en = (state_q == ST_LOOKUP) && rst_n;

   dpi_flow_table #(.KEY_W(KEY_W)) u_flow_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .lookup_en (lookup_en),
      .key       (key_q),
      .res_id    (tbl_id),
      .res_new   (tbl_new)
   );

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      sid_d       = sid_q;
      new_d       = new_q;
      char_d      = char_q;
      char_vld_d  = 1'b0;
      drop_d      = drop_q;
      drain_cnt_d = drain_cnt_q;
      rdy_c       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The SOP byte stays on the bus until STREAM; only its key is taken here.
            if (pkt_vld && pkt_sop) begin
               key_d   = pkt_key;
               state_d = ST_LOOKUP;
            end else if (pkt_vld) begin
               rdy_c  = 1'b1;
               drop_d = 1'b1;
            end
         end
         ST_LOOKUP: begin
            sid_d   = tbl_id;
            new_d   = tbl_new;
            state_d = ST_LOAD;
         end
         ST_LOAD:   state_d = ST_GAP;
         ST_GAP:    state_d = ST_STREAM;
         ST_STREAM: begin
            rdy_c = 1'b1;
            if (pkt_vld) begin
               char_d     = pkt_data;
               char_vld_d = 1'b1;
               if (pkt_eop) begin
                  drain_cnt_d = '0;
                  state_d     = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // First DRAIN cycle carries the last char, then EOP_GAP empty cycles follow.
            if (drain_cnt_q == CNT_W'(EOP_GAP)) begin
               state_d = ST_EOP;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         ST_EOP:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         sid_q       <= '0;
         new_q       <= 1'b0;
         char_q      <= '0;
         char_vld_q  <= 1'b0;
         drop_q      <= 1'b0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         sid_q       <= sid_d;
         new_q       <= new_d;
         char_q      <= char_d;
         char_vld_q  <= char_vld_d;
         drop_q      <= drop_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign pkt_rdy       = rdy_c && rst_n;
   assign char_in       = char_q;
   assign char_in_vld   = char_vld_q;
   assign load_state    = (state_q == ST_LOAD) && rst_n;
   assign new_stream_id = (state_q == ST_LOAD) && new_q && rst_n;
   assign eop           = (state_q == ST_EOP) && rst_n;
   assign stream_id     = sid_q;
   assign drop_err      = drop_q;

`ifdef DPI_FEEDER_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] new_cnt_q, new_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      new_cnt_d = new_cnt_q;
      if (state_q == ST_EOP) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
      if (lookup_en && tbl_new) begin
         new_cnt_d = new_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
         new_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         new_cnt_q <= new_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign new_cnt = new_cnt_q;
`endif

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// tb/tb_dpi_stream_feeder.sv - directed self-checking bench for dpi_stream_feeder
module tb_dpi_stream_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  pkt_data;
   logic        pkt_vld;
   logic        pkt_sop;
   logic        pkt_eop;
   logic [15:0] pkt_key;
   logic        pkt_rdy;
   logic [7:0]  char_in;
   logic        char_in_vld;
   logic        load_state;
   logic [5:0]  stream_id;
   logic        new_stream_id;
   logic        eop;
   logic        drop_err;
`ifdef DPI_FEEDER_STATS_EN
   logic [15:0] pkt_cnt;
   logic [15:0] new_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int overlap_cnt = 0;

   int ld_sid[$];
   int ld_new[$];
   int ld_cyc[$];
   int ch[$];
   int ch_cyc[$];
   int eop_cyc[$];
   int eop_sid[$];

   dpi_stream_feeder #(.KEY_W(16), .EOP_GAP(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pkt_data      (pkt_data),
      .pkt_vld       (pkt_vld),
      .pkt_sop       (pkt_sop),
      .pkt_eop       (pkt_eop),
      .pkt_key       (pkt_key),
      .pkt_rdy       (pkt_rdy),
      .char_in       (char_in),
      .char_in_vld   (char_in_vld),
      .load_state    (load_state),
      .stream_id     (stream_id),
      .new_stream_id (new_stream_id),
      .eop           (eop),
      .drop_err      (drop_err)
`ifdef DPI_FEEDER_STATS_EN
      ,
      .pkt_cnt       (pkt_cnt),
      .new_cnt       (new_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (load_state) begin
         ld_sid.push_back(int'(stream_id));
         ld_new.push_back(int'(new_stream_id));
         ld_cyc.push_back(cyc);
      end
      if (char_in_vld) begin
         ch.push_back(int'(char_in));
         ch_cyc.push_back(cyc);
      end
      if (eop) begin
         eop_cyc.push_back(cyc);
         eop_sid.push_back(int'(stream_id));
      end
      if ((load_state && eop) || (load_state && char_in_vld) || (eop && char_in_vld))
         overlap_cnt++;
   end

   task automatic clear_log();
      ld_sid.delete(); ld_new.delete(); ld_cyc.delete();
      ch.delete(); ch_cyc.delete(); eop_cyc.delete(); eop_sid.delete();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
      pkt_data = 8'h00; pkt_key = 16'h0000;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Sends bytes base..base+len-1; a one-cycle pkt_vld gap follows byte index stall_at-1.
   task automatic send_pkt(input logic [15:0] key, input int len, input logic [7:0] base,
                           input int stall_at);
      int  i = 0;
      int  t = 0;
      bit  acc;
      @(posedge clk); #1;
      pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = (len == 1); pkt_key = key; pkt_data = base;
      while (i < len && t < 200) begin
         @(negedge clk); acc = pkt_rdy; t++;
         @(posedge clk); #1;
         if (acc) begin
            i++;
            if (i == stall_at && i < len) begin
               pkt_vld = 1'b0;
               @(posedge clk); #1;
            end
         end
         if (i < len) begin
            pkt_vld = 1'b1; pkt_sop = (i == 0); pkt_eop = (i == len - 1);
            pkt_data = base + 8'(i);
         end else begin
            pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
         end
      end
      pkt_vld = 1'b0;
      t = 0;
      while (eop_cyc.size() == 0 && t < 30) begin
         @(negedge clk); t++;
      end
      n_checks++;
      if (eop_cyc.size() == 0) begin
         n_errors++;
         $display("FAIL eop_timeout key=%h: no eop seen, required one", key);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_data = 8'h55;
      @(posedge clk); #1;
      n_checks++;
      if ({pkt_rdy, drop_err, char_in_vld, load_state, new_stream_id, eop} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {pkt_rdy, drop_err, char_in_vld, load_state, new_stream_id, eop});
      end
      n_checks++;
      if (char_in !== 8'h00 || stream_id !== 6'd0) begin
         n_errors++;
         $display("FAIL reset_data: char_in=%h stream_id=%0d, required 00/0", char_in, stream_id);
      end
      pkt_vld = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_first();
      clear_log();
      send_pkt(16'h1234, 4, 8'h40, -1);
      n_checks++;
      if (ld_sid.size() != 1) begin
         n_errors++;
         $display("FAIL first_load_count: got %0d, required 1", ld_sid.size());
      end else begin
         n_checks++;
         if (ld_sid[0] != 0 || ld_new[0] != 1) begin
            n_errors++;
            $display("FAIL first_load: sid=%0d new=%0d, required 0/1", ld_sid[0], ld_new[0]);
         end
      end
      n_checks++;
      if (ch.size() != 4) begin
         n_errors++;
         $display("FAIL first_char_count: got %0d, required 4", ch.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ch[k] != 8'h40 + k) begin
               n_errors++;
               $display("FAIL first_char%0d: got %h, required %h", k, ch[k], 8'h40 + k);
            end
         end
         n_checks++;
         if (ld_cyc.size() == 1 && ch_cyc[0] - ld_cyc[0] != 3) begin
            n_errors++;
            $display("FAIL load_to_char: got %0d cycles, required 3", ch_cyc[0] - ld_cyc[0]);
         end
         n_checks++;
         if (eop_cyc.size() != 1 || eop_cyc[0] - ch_cyc[3] != 3) begin
            n_errors++;
            $display("FAIL char_to_eop: eops=%0d gap=%0d, required 1/3", eop_cyc.size(),
                     eop_cyc.size() > 0 ? eop_cyc[0] - ch_cyc[3] : -1);
         end
      end
      n_checks++;
      if (eop_sid.size() == 1 && eop_sid[0] != 0) begin
         n_errors++;
         $display("FAIL eop_sid: got %0d, required 0", eop_sid[0]);
      end
   endtask

   task automatic test_hit();
      clear_log();
      send_pkt(16'h5678, 2, 8'h50, -1);
      n_checks++;
      if (ld_sid.size() != 1 || ld_sid[0] != 1 || ld_new[0] != 1) begin
         n_errors++;
         $display("FAIL miss_5678: loads=%0d sid=%0d new=%0d, required 1/1/1", ld_sid.size(),
                  ld_sid.size() > 0 ? ld_sid[0] : -1, ld_new.size() > 0 ? ld_new[0] : -1);
      end
      clear_log();
      send_pkt(16'h1234, 3, 8'h60, -1);
      n_checks++;
      if (ld_sid.size() != 1 || ld_sid[0] != 0 || ld_new[0] != 0) begin
         n_errors++;
         $display("FAIL hit_1234: loads=%0d sid=%0d new=%0d, required 1/0/0", ld_sid.size(),
                  ld_sid.size() > 0 ? ld_sid[0] : -1, ld_new.size() > 0 ? ld_new[0] : -1);
      end
   endtask

   task automatic test_stall();
      clear_log();
      send_pkt(16'hBEEF, 4, 8'h70, 2);
      n_checks++;
      if (ld_sid.size() != 1 || ld_sid[0] != 2 || ld_new[0] != 1) begin
         n_errors++;
         $display("FAIL stall_load: loads=%0d sid=%0d, required 1/2", ld_sid.size(),
                  ld_sid.size() > 0 ? ld_sid[0] : -1);
      end
      n_checks++;
      if (ch.size() != 4) begin
         n_errors++;
         $display("FAIL stall_char_count: got %0d, required 4", ch.size());
      end else begin
         n_checks++;
         if (ch[0] != 8'h70 || ch[1] != 8'h71 || ch[2] != 8'h72 || ch[3] != 8'h73) begin
            n_errors++;
            $display("FAIL stall_order: got %h %h %h %h, required 70 71 72 73",
                     ch[0], ch[1], ch[2], ch[3]);
         end
         n_checks++;
         if (ch_cyc[1] - ch_cyc[0] != 1 || ch_cyc[2] - ch_cyc[1] != 2 || ch_cyc[3] - ch_cyc[2] != 1) begin
            n_errors++;
            $display("FAIL stall_bubble: gaps %0d %0d %0d, required 1 2 1",
                     ch_cyc[1] - ch_cyc[0], ch_cyc[2] - ch_cyc[1], ch_cyc[3] - ch_cyc[2]);
         end
      end
      n_checks++;
      if (eop_cyc.size() != 1) begin
         n_errors++;
         $display("FAIL stall_eop_count: got %0d, required 1", eop_cyc.size());
      end
   endtask

   task automatic test_drop();
      clear_log();
      @(posedge clk); #1;
      pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'hAA;
      #1;
      n_checks++;
      if (pkt_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL drop_rdy: got %b, required 1", pkt_rdy);
      end
      @(posedge clk); #1;
      pkt_vld = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (drop_err !== 1'b1) begin
         n_errors++;
         $display("FAIL drop_err: got %b, required 1", drop_err);
      end
      n_checks++;
      if (ld_sid.size() != 0 || ch.size() != 0) begin
         n_errors++;
         $display("FAIL drop_quiet: loads=%0d chars=%0d, required 0/0", ld_sid.size(), ch.size());
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int k = 0; k < 65; k++) begin
         clear_log();
         send_pkt(16'h1000 + 16'(k), 1, 8'(k), -1);
         n_checks++;
         if (ld_sid.size() != 1 || ld_sid[0] != k % 64 || ld_new[0] != 1 || ch.size() != 1) begin
            n_errors++;
            $display("FAIL wrap_key%0d: loads=%0d sid=%0d new=%0d chars=%0d, required 1/%0d/1/1",
                     k, ld_sid.size(), ld_sid.size() > 0 ? ld_sid[0] : -1,
                     ld_new.size() > 0 ? ld_new[0] : -1, ch.size(), k % 64);
         end
      end
      clear_log();
      send_pkt(16'h1000, 1, 8'hEE, -1);
      n_checks++;
      if (ld_sid.size() != 1 || ld_sid[0] != 1 || ld_new[0] != 1) begin
         n_errors++;
         $display("FAIL wrap_evicted: loads=%0d sid=%0d new=%0d, required 1/1/1", ld_sid.size(),
                  ld_sid.size() > 0 ? ld_sid[0] : -1, ld_new.size() > 0 ? ld_new[0] : -1);
      end
   endtask

   task automatic test_mid_reset();
      int t = 0;
      bit acc = 1'b0;
      clear_log();
      @(posedge clk); #1;
      pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_key = 16'h4444; pkt_data = 8'h60;
      while (!acc && t < 20) begin
         @(negedge clk); acc = pkt_rdy; t++;
         @(posedge clk); #1;
      end
      pkt_sop = 1'b0; pkt_data = 8'h61;
      @(posedge clk); #1;
      pkt_data = 8'h62;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({pkt_rdy, char_in_vld, load_state, new_stream_id, eop, drop_err} !== 6'b0 ||
          char_in !== 8'h00 || stream_id !== 6'd0) begin
         n_errors++;
         $display("FAIL midrst_outputs: ctrl=%b char=%h sid=%0d, required 000000/00/0",
                  {pkt_rdy, char_in_vld, load_state, new_stream_id, eop, drop_err}, char_in, stream_id);
      end
      n_checks++;
      if (ch.size() < 2) begin
         n_errors++;
         $display("FAIL midrst_streaming: chars=%0d, required at least 2", ch.size());
      end
      pkt_vld = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (eop_cyc.size() != 0) begin
         n_errors++;
         $display("FAIL midrst_eop: got %0d eops, required 0", eop_cyc.size());
      end
      clear_log();
      send_pkt(16'h9999, 2, 8'h80, -1);
      n_checks++;
      if (ld_sid.size() != 1 || ld_sid[0] != 0 || ld_new[0] != 1) begin
         n_errors++;
         $display("FAIL midrst_next: loads=%0d sid=%0d new=%0d, required 1/0/1", ld_sid.size(),
                  ld_sid.size() > 0 ? ld_sid[0] : -1, ld_new.size() > 0 ? ld_new[0] : -1);
      end
   endtask

   task automatic test_exclusive();
      n_checks++;
      if (overlap_cnt != 0) begin
         n_errors++;
         $display("FAIL exclusive: %0d overlapping cycles, required 0", overlap_cnt);
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_first();
      test_hit();
      test_stall();
      test_drop();
      test_wrap();
      test_mid_reset();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
